// File: rtl/ttt_pkg.sv
// Shared constants, state encoding and board helpers for the tic-tac-toe controller.
// Cell i = row*3+col sits at bits [2i+1:2i] of the 18-bit board.
package ttt_pkg;

   localparam logic [1:0] CELL_EMPTY = 2'b00;
   localparam logic [1:0] CELL_HUMAN = 2'b01;
   localparam logic [1:0] CELL_AI    = 2'b10;

   localparam logic [1:0] WIN_NONE  = 2'b00;
   localparam logic [1:0] WIN_HUMAN = 2'b01;
   localparam logic [1:0] WIN_AI    = 2'b10;
   localparam logic [1:0] WIN_DRAW  = 2'b11;

   typedef enum logic [2:0] {
      S_INIT,
      S_H_WAIT,
      S_H_CHECK,
      S_AI_SETTLE,
      S_AI_COMMIT,
      S_A_CHECK,
      S_DONE
   } state_t;

   function automatic logic [3:0] cell_idx(input logic [1:0] row, input logic [1:0] col);
      return ({2'b00, row} * 4'd3) + {2'b00, col};
   endfunction

   // Out-of-range coordinates are illegal regardless of board contents.
   function automatic logic cell_free(input logic [17:0] board, input logic [1:0] row,
                                      input logic [1:0] col);
      logic [17:0] sh;
      if (row > 2'd2 || col > 2'd2) return 1'b0;
      sh = board >> {cell_idx(row, col), 1'b0};
      return sh[1:0] == CELL_EMPTY;
   endfunction

   function automatic logic [17:0] set_cell(input logic [17:0] board, input logic [3:0] idx,
                                            input logic [1:0] val);
      return board | ({16'b0, val} << {idx, 1'b0});
   endfunction

endpackage

// File: rtl/ttt_board_ctrl_if.sv
// Handshake and board bus between the game driver/ai stub (master) and the controller (slave).
interface ttt_board_ctrl_if;
   logic        new_game;
   logic        move_valid;
   logic        move_ready;
   logic [1:0]  move_row;
   logic [1:0]  move_col;
   logic        move_err;
   logic [17:0] registers;
   logic [1:0]  ai_row;
   logic [1:0]  ai_col;
   logic        ai_err;
   logic        game_over;
   logic [1:0]  winner;

   modport master (
      output new_game, move_valid, move_row, move_col, ai_row, ai_col,
      input  move_ready, move_err, registers, ai_err, game_over, winner
   );

   modport slave (
      input  new_game, move_valid, move_row, move_col, ai_row, ai_col,
      output move_ready, move_err, registers, ai_err, game_over, winner
   );
endinterface

// File: rtl/ttt_line_detect.sv
// Combinational board evaluation: does i_player own any of the 8 lines, and is every cell used.
module ttt_line_detect
   import ttt_pkg::*;
(
   input  logic [17:0] i_registers,
   input  logic [1:0]  i_player,
   output logic        o_has_line,
   output logic        o_board_full
);

   logic [8:0] w_own;
   logic [8:0] w_used;

   always_comb begin
      w_own  = '0;
      w_used = '0;
      for (int i = 0; i < 9; i++) begin
         w_own[i]  = (i_registers[2*i +: 2] == i_player);
         w_used[i] = (i_registers[2*i +: 2] != CELL_EMPTY);
      end
   end

   assign o_has_line = (&w_own[2:0]) | (&w_own[5:3]) | (&w_own[8:6])
                     | (w_own[0] & w_own[3] & w_own[6])
                     | (w_own[1] & w_own[4] & w_own[7])
                     | (w_own[2] & w_own[5] & w_own[8])
                     | (w_own[0] & w_own[4] & w_own[8])
                     | (w_own[2] & w_own[4] & w_own[6]);

   assign o_board_full = &w_used;

endmodule

// File: rtl/ttt_board_ctrl.sv
// Board owner: applies human moves, waits AI_SETTLE cycles for the ai block, commits its move,
// and latches win/draw/ai-error until new_game or reset.
module ttt_board_ctrl
   import ttt_pkg::*;
#(
   parameter int AI_SETTLE   = 2,
   parameter bit HUMAN_FIRST = 1'b1
)
(
   input  logic           clk,
   input  logic           rst_n,
   ttt_board_ctrl_if.slave bus
);

   state_t      r_state;
   logic [3:0]  r_cnt;
   logic [17:0] r_registers;
   logic        r_move_err;
   logic        r_ai_err;
   logic        r_game_over;
   logic [1:0]  r_winner;

   logic        w_move_legal;
   logic        w_ai_legal;
   logic [3:0]  w_move_idx;
   logic [3:0]  w_ai_idx;
   logic [1:0]  w_player;
   logic        w_has_line;
   logic        w_full;

   assign w_move_legal = cell_free(r_registers, bus.move_row, bus.move_col);
   assign w_ai_legal   = cell_free(r_registers, bus.ai_row, bus.ai_col);
   assign w_move_idx   = cell_idx(bus.move_row, bus.move_col);
   assign w_ai_idx     = cell_idx(bus.ai_row, bus.ai_col);
   assign w_player     = (r_state == S_A_CHECK) ? CELL_AI : CELL_HUMAN;

   ttt_line_detect u_line_detect (
      .i_registers  (r_registers),
      .i_player     (w_player),
      .o_has_line   (w_has_line),
      .o_board_full (w_full)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= S_INIT;
         r_cnt       <= '0;
         r_registers <= '0;
         r_move_err  <= 1'b0;
         r_ai_err    <= 1'b0;
         r_game_over <= 1'b0;
         r_winner    <= WIN_NONE;
      end else if (bus.new_game) begin
         r_state     <= S_INIT;
         r_cnt       <= '0;
         r_registers <= '0;
         r_move_err  <= 1'b0;
         r_ai_err    <= 1'b0;
         r_game_over <= 1'b0;
         r_winner    <= WIN_NONE;
      end else begin
         r_move_err <= 1'b0;
         case (r_state)
            S_INIT: begin
               r_cnt   <= '0;
               r_state <= HUMAN_FIRST ? S_H_WAIT : S_AI_SETTLE;
            end
            S_H_WAIT: begin
               if (bus.move_valid) begin
                  if (w_move_legal) begin
                     r_registers <= set_cell(r_registers, w_move_idx, CELL_HUMAN);
                     r_state     <= S_H_CHECK;
                  end else begin
                     r_move_err <= 1'b1;
                  end
               end
            end
            S_H_CHECK, S_A_CHECK: begin
               // The detector is pointed at whoever just moved, selected from r_state.
               if (w_has_line) begin
                  r_winner    <= (r_state == S_A_CHECK) ? WIN_AI : WIN_HUMAN;
                  r_game_over <= 1'b1;
                  r_state     <= S_DONE;
               end else if (w_full) begin
                  r_winner    <= WIN_DRAW;
                  r_game_over <= 1'b1;
                  r_state     <= S_DONE;
               end else if (r_state == S_H_CHECK) begin
                  r_cnt   <= '0;
                  r_state <= S_AI_SETTLE;
               end else begin
                  r_state <= S_H_WAIT;
               end
            end
            S_AI_SETTLE: begin
               r_cnt <= r_cnt + 4'd1;
               if (r_cnt == 4'(AI_SETTLE - 1)) r_state <= S_AI_COMMIT;
            end
            S_AI_COMMIT: begin
               if (w_ai_legal) begin
                  r_registers <= set_cell(r_registers, w_ai_idx, CELL_AI);
                  r_state     <= S_A_CHECK;
               end else begin
                  r_ai_err    <= 1'b1;
                  r_game_over <= 1'b1;
                  r_state     <= S_DONE;
               end
            end
            S_DONE:  r_state <= S_DONE;
            default: r_state <= S_INIT;
         endcase
      end
   end

   assign bus.move_ready = (r_state == S_H_WAIT);
   assign bus.move_err   = r_move_err;
   assign bus.registers  = r_registers;
   assign bus.ai_err     = r_ai_err;
   assign bus.game_over  = r_game_over;
   assign bus.winner     = r_winner;

endmodule

// File: doc/ttt_board_ctrl.md
Name: ttt_board_ctrl

Overview:
- Sequential owner of the 18-bit tic-tac-toe board. It accepts human moves over a valid/ready handshake and applies them to the board.
- It then drives the board to the combinational move generator `ai`, waits a fixed settle time, and commits the returned row/col as the AI move.
- It detects win, draw and illegal moves, and holds the game-over state until a new game is requested.
- It is the writer of the board state that `ai` reads.

Parameters:
- AI_SETTLE, default 2: cycles between driving an updated board and sampling ai_row/ai_col; legal range 1..15.
- HUMAN_FIRST, default 1: 1 = human moves first after reset/new_game; 0 = AI moves first.

Ports:
- clk  input  1  system clock; all state on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- new_game  input  1  synchronous clear of board and status; has priority over every other input.
- move_valid  input  1  human move offered.
- move_ready  output  1  controller can accept a human move this cycle.
- move_row  input  2  human row, 0..2.
- move_col  input  2  human column, 0..2.
- move_err  output  1  one-cycle pulse: offered human move was illegal and was discarded.
- registers  output  18  board state; cell i = row*3+col occupies bits [2i+1:2i].
- ai_row  input  2  row returned by ai for the current registers value.
- ai_col  input  2  column returned by ai for the current registers value.
- ai_err  output  1  sticky: ai returned an illegal move; cleared by reset or new_game.
- game_over  output  1  high once a win, draw or ai_err is reached.
- winner  output  2  00 none, 01 human, 10 AI, 11 draw.

Behaviour:
- Cell encoding: 00 empty, 01 human, 10 AI, 11 never written.
- Reset (rst_n low, asynchronous) and new_game (synchronous) both set:
  - registers=0, move_ready=0, move_err=0, ai_err=0, game_over=0, winner=00.
  - State goes to INIT.
- INIT: on the next cycle, go to H_WAIT if HUMAN_FIRST=1, else AI_SETTLE.
- H_WAIT: move_ready=1. A human move is accepted when move_valid && move_ready.
  - The move is legal when row<=2, col<=2 and the target cell is 00.
  - Legal move: write 01 into the cell on the accepting edge, then go to H_CHECK.
  - Illegal move: move_err=1 for the following cycle, board unchanged, stay in H_WAIT.
- H_CHECK: move_ready=0; evaluate the board.
  - Human has a line: winner=01, go to DONE.
  - Else board full: winner=11, go to DONE.
  - Else: go to AI_SETTLE, counter=0.
- AI_SETTLE: move_ready=0; the counter increments each cycle. When the counter reaches AI_SETTLE-1, go to AI_COMMIT.
- AI_COMMIT: sample ai_row/ai_col.
  - Legal (same rule as the human move): write 10 into the cell, go to A_CHECK.
  - Illegal: ai_err=1, game_over=1, winner unchanged (00), go to DONE.
- A_CHECK:
  - AI has a line: winner=10, go to DONE.
  - Else board full: winner=11, go to DONE.
  - Else: go to H_WAIT.
- DONE: game_over=1, move_ready=0, registers frozen. move_valid is ignored with no move_err. Only new_game or reset exits.
- Line check covers 8 lines: 3 rows, 3 columns, 2 diagonals. A win test uses only the player who just moved.
- Latency from accepting a human move to the AI write edge is 1 + AI_SETTLE + 1 cycles.
- move_err is a single-cycle pulse per rejected offer. A held illegal move_valid re-pulses every cycle.
- Simultaneous new_game and an accepted move: new_game wins; the move is dropped and move_err is not pulsed.

Decomposition:
- ttt_pkg holds:
  - cell constants CELL_EMPTY, CELL_HUMAN, CELL_AI.
  - winner codes WIN_NONE, WIN_HUMAN, WIN_AI, WIN_DRAW.
  - state enum INIT, H_WAIT, H_CHECK, AI_SETTLE, AI_COMMIT, A_CHECK, DONE.
  - function cell_idx(row,col).
- Sub-module ttt_line_detect (combinational):
  - inputs registers[17:0] and player[1:0].
  - outputs has_line and board_full.
  - Instantiated once, with player selected by state.

Test Plan:
- Reset then HUMAN_FIRST=1; move (1,1) -> registers=18'h00100 (bits 9:8=01). AI_SETTLE=2 cycles later, with ai_row/col driving (0,0), the AI write sets bits 1:0=10 at the 4th cycle after the accepting edge.
- Human offers (1,1) again on an occupied cell -> move_err one-cycle pulse, registers unchanged, move_ready stays 1. Offer (3,0) -> move_err pulse.
- Human plays (0,0),(0,1),(0,2) while the AI stub returns (2,0),(2,1) -> winner=01, game_over=1 in the H_CHECK cycle after the third accept, and no AI write follows.
- AI stub returns an occupied cell -> ai_err=1, game_over=1, winner=00, registers unchanged. A subsequent new_game clears all to 0 and returns to H_WAIT.
- Scripted full-board game with no line -> winner=11 after the 9th write.
- Assert rst_n low mid AI_SETTLE -> outputs go to reset values immediately (asynchronous), before the next clock edge.
